// File: rtl/seq_parser_pkg.sv
// Shared types, header byte-lane helpers and flag positions for the multi-stream sequence parser.
package seq_parser_pkg;

  localparam int unsigned MAX_PAYLOAD = 37;
  localparam int unsigned SEQ_W       = 32;
  localparam int unsigned HDR_BYTES   = 8;
  localparam int unsigned BEAT_BYTES  = 4;
  localparam int unsigned PAYLOAD_W   = MAX_PAYLOAD * 8;
  localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1);

  // Byte lane 0 is the first byte on the wire and sits at dataIn[31:24].
  localparam int unsigned LANE_LEN_LO = 0;
  localparam int unsigned LANE_LEN_HI = 1;
  localparam int unsigned LANE_SID_LO = 2;
  localparam int unsigned LANE_SID_HI = 3;

  localparam int unsigned FLAG_LOST       = 0;
  localparam int unsigned FLAG_LATE       = 1;
  localparam int unsigned FLAG_BADLEN     = 2;
  localparam int unsigned FLAG_BADSTREAM  = 3;

  typedef enum logic [1:0] {IDLE, HDR1, DATA} rx_state_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [LEN_W-1:0]     len;
    logic [15:0]          stream;
    logic [SEQ_W-1:0]     gap;
    logic [3:0]           flags;
  } pkt_entry_t;

  function automatic logic [7:0] laneByte(input logic [31:0] d, input int unsigned lane);
    return d[31 - 8*lane -: 8];
  endfunction

  function automatic logic [15:0] hdrLen(input logic [31:0] d);
    return {laneByte(d, LANE_LEN_HI), laneByte(d, LANE_LEN_LO)};
  endfunction

  function automatic logic [15:0] hdrStream(input logic [31:0] d);
    return {laneByte(d, LANE_SID_HI), laneByte(d, LANE_SID_LO)};
  endfunction

  // Sequence number is little-endian across the four lanes of header word 1.
  function automatic logic [SEQ_W-1:0] hdrSeq(input logic [31:0] d);
    return SEQ_W'({laneByte(d, 3), laneByte(d, 2), laneByte(d, 1), laneByte(d, 0)});
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO of parsed packet entries; an extra pointer bit separates full from empty.
module pkt_fifo
  import seq_parser_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pkt_entry_t pushData,
  input  logic       pop,
  output pkt_entry_t popData,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pkt_entry_t    mem [DEPTH];
  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic          doPush;
  logic          doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/seq_parser_mc.sv
// Multi-stream sequence parser: strips the 8-byte header, classifies each packet against a
// per-stream next-expected sequence table and queues the result in an output FIFO.
module seq_parser_mc
  import seq_parser_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 32,
  parameter int unsigned DEPTH       = 4,
  parameter bit          DROP_BAD    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          dataIn,
  input  logic                 dataIn_val,
  output logic                 dataIn_ready,
  input  logic                 dataIN_last,
  output logic [PAYLOAD_W-1:0] dataOut,
  output logic [LEN_W-1:0]     dataOut_len,
  output logic [15:0]          dataOut_stream,
  output logic [SEQ_W-1:0]     dataOut_gap,
  output logic [3:0]           dataOut_flags,
  output logic                 dataOut_val,
  input  logic                 dataOut_ready,
  output logic [15:0]          runtCount
);

  localparam int unsigned IDX_W         = $clog2(NUM_STREAMS);
  localparam logic [15:0] NUM_STREAMS_L = 16'(NUM_STREAMS);
  localparam logic [15:0] MIN_LEN       = 16'(HDR_BYTES + 1);
  localparam logic [15:0] MAX_LEN       = 16'(MAX_PAYLOAD + HDR_BYTES);

  rx_state_e            state;
  logic [15:0]          hdrLenQ;
  logic [15:0]          streamId;
  logic [SEQ_W-1:0]     seqNum;
  logic [15:0]          bytesLeft;
  logic [7:0]           byteIdx;
  logic [PAYLOAD_W-1:0] payload;
  logic                 lenBad;
  logic [SEQ_W-1:0]     seqTable [NUM_STREAMS];

  logic                 beatAcc;
  logic [15:0]          lenIn;
  logic [PAYLOAD_W-1:0] payloadNext;
  logic                 lastBad;
  logic                 badStream;
  logic [SEQ_W-1:0]     gap;
  logic                 late;
  logic                 lost;
  logic                 push;
  logic                 fifoFull;
  logic                 fifoEmpty;
  pkt_entry_t           pushEntry;
  pkt_entry_t           headEntry;

  assign dataIn_ready = !fifoFull && !reset;
  assign beatAcc      = dataIn_val && dataIn_ready;
  assign lenIn        = hdrLen(dataIn);

  // Entry assembly for the beat currently on the bus (only pushed on a DATA last beat).
  always_comb begin
    payloadNext = payload;
    for (int j = 0; j < int'(BEAT_BYTES); j++) begin
      if ((32'(byteIdx) + 32'(j)) < MAX_PAYLOAD &&
          (!dataIN_last || 32'(j) < 32'(bytesLeft)))
        payloadNext[(PAYLOAD_W - 8) - 8*(32'(byteIdx) + 32'(j)) +: 8] = laneByte(dataIn, 32'(j));
    end
    lastBad   = lenBad || (bytesLeft == 16'd0) || (bytesLeft > 16'(BEAT_BYTES));
    badStream = (streamId >= NUM_STREAMS_L);
    gap       = badStream ? '0 : (seqNum - seqTable[streamId[IDX_W-1:0]]);
    late      = gap[SEQ_W-1];
    lost      = (gap != '0) && !gap[SEQ_W-1];

    pushEntry.payload = lastBad ? '1 : payloadNext;
    pushEntry.len     = lastBad ? LEN_W'(MAX_PAYLOAD) : LEN_W'(hdrLenQ - 16'(HDR_BYTES));
    pushEntry.stream  = streamId;
    pushEntry.gap     = gap;
    pushEntry.flags   = '0;
    pushEntry.flags[FLAG_LOST]      = lost;
    pushEntry.flags[FLAG_LATE]      = late;
    pushEntry.flags[FLAG_BADLEN]    = lastBad;
    pushEntry.flags[FLAG_BADSTREAM] = badStream;

    push = (state == DATA) && beatAcc && dataIN_last && !(DROP_BAD && lastBad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hdrLenQ   <= '0;
      streamId  <= '0;
      seqNum    <= '0;
      bytesLeft <= '0;
      byteIdx   <= '0;
      payload   <= '0;
      lenBad    <= 1'b0;
      runtCount <= '0;
      for (int i = 0; i < int'(NUM_STREAMS); i++) seqTable[i] <= '0;
    end else if (beatAcc) begin
      case (state)
        IDLE: begin
          hdrLenQ   <= lenIn;
          streamId  <= hdrStream(dataIn);
          bytesLeft <= lenIn - 16'(HDR_BYTES);
          lenBad    <= (lenIn < MIN_LEN) || (lenIn > MAX_LEN);
          byteIdx   <= '0;
          payload   <= '0;
          if (dataIN_last) begin
            if (runtCount != 16'hFFFF) runtCount <= runtCount + 16'd1;
          end else begin
            state <= HDR1;
          end
        end
        HDR1: begin
          seqNum <= hdrSeq(dataIn);
          if (dataIN_last) begin
            if (runtCount != 16'hFFFF) runtCount <= runtCount + 16'd1;
            state <= IDLE;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          payload <= payloadNext;
          // Index stops advancing once past the stored region; overflow beats are dropped.
          if (byteIdx < 8'(MAX_PAYLOAD)) byteIdx <= byteIdx + 8'(BEAT_BYTES);
          if (dataIN_last) begin
            state <= IDLE;
            if (!badStream && !lastBad && !late)
              seqTable[streamId[IDX_W-1:0]] <= seqNum + SEQ_W'(1);
          end else begin
            bytesLeft <= (bytesLeft > 16'(BEAT_BYTES)) ? bytesLeft - 16'(BEAT_BYTES) : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushEntry),
    .pop      (dataOut_ready),
    .popData  (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Egress fields come straight from the FIFO head and read as zero when it is empty.
  always_comb begin
    dataOut_val    = !fifoEmpty;
    dataOut        = '0;
    dataOut_len    = '0;
    dataOut_stream = '0;
    dataOut_gap    = '0;
    dataOut_flags  = '0;
    if (dataOut_val) begin
      dataOut        = headEntry.payload;
      dataOut_len    = headEntry.len;
      dataOut_stream = headEntry.stream;
      dataOut_gap    = headEntry.gap;
      dataOut_flags  = headEntry.flags;
    end
  end

endmodule

// File: tb/tb_seq_parser_mc.sv
// Directed self-checking bench for seq_parser_mc with hand-computed expected entries.
module tb_seq_parser_mc;
  import seq_parser_pkg::*;

  logic                 clk;
  logic                 reset;
  logic [31:0]          dataIn;
  logic                 dataIn_val;
  logic                 dataIn_ready;
  logic                 dataIN_last;
  logic [PAYLOAD_W-1:0] dataOut;
  logic [LEN_W-1:0]     dataOut_len;
  logic [15:0]          dataOut_stream;
  logic [SEQ_W-1:0]     dataOut_gap;
  logic [3:0]           dataOut_flags;
  logic                 dataOut_val;
  logic                 dataOut_ready;
  logic [15:0]          runtCount;

  int nCmp = 0;
  int nBad = 0;

  seq_parser_mc #(.NUM_STREAMS(32), .DEPTH(4), .DROP_BAD(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .dataIn         (dataIn),
    .dataIn_val     (dataIn_val),
    .dataIn_ready   (dataIn_ready),
    .dataIN_last    (dataIN_last),
    .dataOut        (dataOut),
    .dataOut_len    (dataOut_len),
    .dataOut_stream (dataOut_stream),
    .dataOut_gap    (dataOut_gap),
    .dataOut_flags  (dataOut_flags),
    .dataOut_val    (dataOut_val),
    .dataOut_ready  (dataOut_ready),
    .runtCount      (runtCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [PAYLOAD_W-1:0] got,
                          input logic [PAYLOAD_W-1:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkHdr0(input logic [15:0] len, input logic [15:0] sid);
    return {len[7:0], len[15:8], sid[7:0], sid[15:8]};
  endfunction

  function automatic logic [31:0] mkHdr1(input logic [31:0] seq);
    return {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
  endfunction

  function automatic logic [PAYLOAD_W-1:0] expPl(input logic [7:0] seed, input int n);
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    for (int i = 0; i < int'(MAX_PAYLOAD); i++)
      if (i < n) p[(PAYLOAD_W - 8) - 8*i +: 8] = 8'(seed + 8'(i));
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic sendBeat(input logic [31:0] d, input logic l);
    int waitCyc;
    waitCyc     = 0;
    dataIn      = d;
    dataIn_val  = 1'b1;
    dataIN_last = l;
    while (!dataIn_ready && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!dataIn_ready) checkVal("sendBeat.ready", PAYLOAD_W'(dataIn_ready), PAYLOAD_W'(1));
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;
  endtask

  task automatic sendPkt(input logic [15:0] sid, input logic [15:0] len, input logic [31:0] seq,
                         input int nBeats, input logic [7:0] seed);
    logic [7:0] b;
    sendBeat(mkHdr0(len, sid), 1'b0);
    sendBeat(mkHdr1(seq), 1'b0);
    for (int k = 0; k < nBeats; k++) begin
      b = 8'(seed + 8'(4*k));
      sendBeat({b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)}, k == nBeats - 1);
    end
  endtask

  task automatic popCheck(input string tag, input logic [15:0] sid, input logic [LEN_W-1:0] len,
                          input logic [31:0] gap, input logic [3:0] flags,
                          input logic [PAYLOAD_W-1:0] pl);
    int n;
    n = 0;
    while (!dataOut_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, ".val"}, PAYLOAD_W'(dataOut_val), PAYLOAD_W'(1));
    if (dataOut_val) begin
      checkVal({tag, ".stream"},  PAYLOAD_W'(dataOut_stream), PAYLOAD_W'(sid));
      checkVal({tag, ".len"},     PAYLOAD_W'(dataOut_len),    PAYLOAD_W'(len));
      checkVal({tag, ".gap"},     PAYLOAD_W'(dataOut_gap),    PAYLOAD_W'(gap));
      checkVal({tag, ".flags"},   PAYLOAD_W'(dataOut_flags),  PAYLOAD_W'(flags));
      checkVal({tag, ".payload"}, dataOut, pl);
      dataOut_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dataOut_ready = 1'b0;
    end
  endtask

  initial begin
    logic [PAYLOAD_W-1:0] allFF;
    logic [PAYLOAD_W-1:0] plT3;
    allFF = '1;
    reset = 1'b1;
    dataIn = '0;
    dataIn_val = 1'b0;
    dataIN_last = 1'b0;
    dataOut_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rst.ready", PAYLOAD_W'(dataIn_ready), '0);
    checkVal("rst.val",   PAYLOAD_W'(dataOut_val),  '0);
    checkVal("rst.runt",  PAYLOAD_W'(runtCount),    '0);
    checkVal("rst.data",  dataOut, '0);
    reset = 1'b0;
    @(negedge clk);

    // Max-length in-order packets on stream 3
    sendPkt(16'd3, 16'd45, 32'd0, 10, 8'h01);
    checkVal("t1.latency", PAYLOAD_W'(dataOut_val), PAYLOAD_W'(1));
    popCheck("t1.a", 16'd3, 6'd37, 32'd0, 4'b0000, expPl(8'h01, 37));
    sendPkt(16'd3, 16'd45, 32'd1, 10, 8'h40);
    popCheck("t1.b", 16'd3, 6'd37, 32'd0, 4'b0000, expPl(8'h40, 37));
    sendPkt(16'd3, 16'd12, 32'd2, 1, 8'h70);
    popCheck("t1.c", 16'd3, 6'd4, 32'd0, 4'b0000, expPl(8'h70, 4));

    // Gap and late detection on stream 5
    sendPkt(16'd5, 16'd12, 32'd0, 1, 8'h20);
    popCheck("t2.a", 16'd5, 6'd4, 32'd0, 4'b0000, expPl(8'h20, 4));
    sendPkt(16'd5, 16'd12, 32'd4, 1, 8'h24);
    popCheck("t2.lost", 16'd5, 6'd4, 32'd3, 4'b0001, expPl(8'h24, 4));
    sendPkt(16'd5, 16'd12, 32'd2, 1, 8'h28);
    popCheck("t2.late", 16'd5, 6'd4, 32'hFFFF_FFFD, 4'b0010, expPl(8'h28, 4));
    sendPkt(16'd5, 16'd12, 32'd5, 1, 8'h2C);
    popCheck("t2.resume", 16'd5, 6'd4, 32'd0, 4'b0000, expPl(8'h2C, 4));

    // Partial last beat and length errors on stream 7
    sendBeat(mkHdr0(16'd14, 16'd7), 1'b0);
    sendBeat(mkHdr1(32'd0), 1'b0);
    sendBeat(32'h11223344, 1'b0);
    sendBeat(32'hAABBCCDD, 1'b1);
    plT3 = '0;
    plT3[PAYLOAD_W-1 -: 48] = 48'h11223344AABB;
    popCheck("t3.partial", 16'd7, 6'd6, 32'd0, 4'b0000, plT3);
    sendPkt(16'd7, 16'd13, 32'd1, 3, 8'h90);
    popCheck("t3.extraBeat", 16'd7, 6'd37, 32'd0, 4'b0100, allFF);
    sendPkt(16'd7, 16'd46, 32'd1, 10, 8'h90);
    popCheck("t3.tooLong", 16'd7, 6'd37, 32'd0, 4'b0100, allFF);
    sendPkt(16'd7, 16'd12, 32'd1, 1, 8'hA0);
    popCheck("t3.tableKept", 16'd7, 6'd4, 32'd0, 4'b0000, expPl(8'hA0, 4));

    // Backpressure: five packets into a four-entry FIFO
    fork
      begin
        for (int k = 0; k < 5; k++) sendPkt(16'd9, 16'd12, 32'(k), 1, 8'(8'h80 + 8'(4*k)));
      end
      begin
        repeat (20) @(negedge clk);
        checkVal("t4.readyLow", PAYLOAD_W'(dataIn_ready), '0);
        for (int k = 0; k < 5; k++)
          popCheck("t4.pop", 16'd9, 6'd4, 32'd0, 4'b0000, expPl(8'(8'h80 + 8'(4*k)), 4));
      end
    join

    // Runts and out-of-range stream
    sendBeat(mkHdr0(16'd12, 16'd4), 1'b0);
    sendBeat(mkHdr1(32'd9), 1'b1);
    checkVal("t5.runt1", PAYLOAD_W'(runtCount), PAYLOAD_W'(1));
    sendBeat(mkHdr0(16'd12, 16'd4), 1'b1);
    checkVal("t5.runt2", PAYLOAD_W'(runtCount), PAYLOAD_W'(2));
    checkVal("t5.noEntry", PAYLOAD_W'(dataOut_val), '0);
    sendPkt(16'd40, 16'd12, 32'd7, 1, 8'hC0);
    popCheck("t5.badStream", 16'd40, 6'd4, 32'd0, 4'b1000, expPl(8'hC0, 4));
    sendPkt(16'd8, 16'd12, 32'd0, 1, 8'hC4);
    popCheck("t5.alias", 16'd8, 6'd4, 32'd0, 4'b0000, expPl(8'hC4, 4));

    // Reset in the middle of a packet with an entry still queued
    sendPkt(16'd2, 16'd12, 32'd0, 1, 8'h50);
    checkVal("t6.pending", PAYLOAD_W'(dataOut_val), PAYLOAD_W'(1));
    sendBeat(mkHdr0(16'd20, 16'd2), 1'b0);
    sendBeat(mkHdr1(32'd1), 1'b0);
    sendBeat(32'h01020304, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkVal("t6.rstReady", PAYLOAD_W'(dataIn_ready), '0);
    checkVal("t6.rstVal",   PAYLOAD_W'(dataOut_val),  '0);
    checkVal("t6.rstData",  dataOut, '0);
    reset = 1'b0;
    @(negedge clk);
    checkVal("t6.runt", PAYLOAD_W'(runtCount), '0);
    sendPkt(16'd2, 16'd12, 32'd0, 1, 8'h60);
    popCheck("t6.after", 16'd2, 6'd4, 32'd0, 4'b0000, expPl(8'h60, 4));
    checkVal("t6.emptyEnd", PAYLOAD_W'(dataOut_val), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
